// File: rtl/cnt_rr_scheduler.sv
// cnt_rr_scheduler
// Shares one up-counter among N_REQ requesters. A round-robin arbiter picks
// one requester. The FSM then enables the counter for exactly the requested
// burst length, pulses done with the winner's index and rotates priority.
// Every output comes straight from a flop.
module cnt_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 6,
  parameter int IDX_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   req_len,
  output logic [N_REQ-1:0]         gnt,
  output logic                     data_valid,
  output logic [CNT_W-1:0]         cnt,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t           state;
  state_t           state_next;

  // The priority pointer and the winner are kept as indices. The one-hot
  // grant is rebuilt from the winner when the grant is issued.
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] win_next;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_next;

  logic [N_REQ-1:0] gnt_next;
  logic             data_valid_next;
  logic [CNT_W-1:0] cnt_next;
  logic             busy_next;
  logic             done_next;
  logic [IDX_W-1:0] done_id_next;

  logic [CNT_W-1:0] len_arr [N_REQ];
  logic [IDX_W-1:0] pick;
  logic [CNT_W-1:0] term;

  // Split the flat length bus into one field per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*CNT_W +: CNT_W];
  end

  // The last counting value is len_q-1, taken modulo 2^CNT_W. A zero length
  // therefore ends at all ones and runs 2^CNT_W cycles with no special case.
  assign term = len_q - CNT_W'(1);

  // Round-robin search. Start at ptr and take the first set request,
  // wrapping from the last index back to 0.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // Next-state and next-output logic. Every register holds its value
  // unless the current state says otherwise.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    win_next        = win_q;
    len_next        = len_q;
    gnt_next        = gnt;
    data_valid_next = data_valid;
    cnt_next        = cnt;
    busy_next       = busy;
    done_next       = done;
    done_id_next    = done_id;

    case (state)
      IDLE: begin
        if (|req) begin
          win_next        = pick;
          len_next        = len_arr[pick];
          gnt_next        = N_REQ'(1) << pick;
          cnt_next        = '0;
          data_valid_next = 1'b1;
          busy_next       = 1'b1;
          state_next      = RUN;
        end
      end

      RUN: begin
        // The burst does not depend on req after the grant. Dropping a
        // request cannot end the burst early.
        if (cnt == term) begin
          gnt_next        = '0;
          data_valid_next = 1'b0;
          done_next       = 1'b1;
          done_id_next    = win_q;
          ptr_next        = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
          state_next      = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        // cnt keeps its final value here and is cleared only at the next grant.
        done_next  = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset forces IDLE at once, including in mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers, loaded from the next-value logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      win_q      <= '0;
      len_q      <= '0;
      gnt        <= '0;
      data_valid <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
    end else begin
      ptr        <= ptr_next;
      win_q      <= win_next;
      len_q      <= len_next;
      gnt        <= gnt_next;
      data_valid <= data_valid_next;
      cnt        <= cnt_next;
      busy       <= busy_next;
      done       <= done_next;
      done_id    <= done_id_next;
    end
  end

endmodule

// File: tb/tb_cnt_rr_scheduler.sv
// Directed testbench for cnt_rr_scheduler with 4 requesters and a 6-bit counter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cnt_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 6;
  localparam int IDX_W = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic [N_REQ-1:0]       gnt;
  logic                   data_valid;
  logic [CNT_W-1:0]       cnt;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       done_id;

  int compare_count;
  int fail_count;

  cnt_rr_scheduler #(
    .N_REQ(N_REQ),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_len(req_len),
    .gnt(gnt),
    .data_valid(data_valid),
    .cnt(cnt),
    .busy(busy),
    .done(done),
    .done_id(done_id)
  );

  // Free-running clock with a 10ns period. The first rising edge is at 5ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N_REQ*CNT_W-1:0] pack_lens(input logic [CNT_W-1:0] l0,
                                                       input logic [CNT_W-1:0] l1,
                                                       input logic [CNT_W-1:0] l2,
                                                       input logic [CNT_W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ*CNT_W-1:0] lens);
    req     = r;
    req_len = lens;
  endtask

  // The vector is {gnt, data_valid, cnt, busy, done, done_id}.
  task automatic checkOutput(input string tag,
                             input logic [N_REQ-1:0] e_gnt, input logic e_dv,
                             input logic [CNT_W-1:0] e_cnt, input logic e_busy,
                             input logic e_done, input logic [IDX_W-1:0] e_id);
    logic [14:0] obs;
    logic [14:0] exp;
    obs = {gnt, data_valid, cnt, busy, done, done_id};
    exp = {e_gnt, e_dv, e_cnt, e_busy, e_done, e_id};
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed gnt/dv/cnt/busy/done/id=%b/%b/%0d/%b/%b/%0d expected %b/%b/%0d/%b/%b/%0d",
             tag, gnt, data_valid, cnt, busy, done, done_id,
             e_gnt, e_dv, e_cnt, e_busy, e_done, e_id);
    end
  endtask

  initial begin
    logic [IDX_W-1:0] order [6];
    logic [IDX_W-1:0] prev_id;
    compare_count = 0;
    fail_count    = 0;
    applyStimulus(4'b0000, '0);
    rst = 1'b0;

    // 1: reset, then idle with no requests
    #2 rst = 1'b1;
    #1 checkOutput("reset_active", 4'b0000, 0, 0, 0, 0, 0);
    #4 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("idle_no_req", 4'b0000, 0, 0, 0, 0, 0);
    end

    // 2: single burst of length 5 on requester 0
    applyStimulus(4'b0001, pack_lens(6'd5, 6'd0, 6'd0, 6'd0));
    tick();
    checkOutput("t2_grant", 4'b0001, 1, 0, 1, 0, 0);
    applyStimulus(4'b0000, pack_lens(6'd5, 6'd0, 6'd0, 6'd0));
    for (int c = 1; c < 5; c++) begin
      tick();
      checkOutput("t2_count", 4'b0001, 1, 6'(c), 1, 0, 0);
    end
    tick();
    checkOutput("t2_done", 4'b0000, 0, 4, 1, 1, 0);
    tick();
    checkOutput("t2_busy_fall", 4'b0000, 0, 4, 0, 0, 0);

    // 3: all four requesting with length 2, starting from ptr=0 after reset
    rst = 1'b1;
    #1 rst = 1'b0;
    applyStimulus(4'b1111, pack_lens(6'd2, 6'd2, 6'd2, 6'd2));
    order[0] = 0; order[1] = 1; order[2] = 2;
    order[3] = 3; order[4] = 0; order[5] = 1;
    prev_id = 0;
    for (int b = 0; b < 6; b++) begin
      tick();
      checkOutput("t3_grant", 4'(1) << order[b], 1, 0, 1, 0, prev_id);
      tick();
      checkOutput("t3_count1", 4'(1) << order[b], 1, 1, 1, 0, prev_id);
      tick();
      checkOutput("t3_done", 4'b0000, 0, 1, 1, 1, order[b]);
      tick();
      checkOutput("t3_gap", 4'b0000, 0, 1, 0, 0, order[b]);
      prev_id = order[b];
    end
    applyStimulus(4'b0000, pack_lens(6'd2, 6'd2, 6'd2, 6'd2));

    // 4: length 0 on requester 2 runs 64 cycles (ptr is 2 here)
    applyStimulus(4'b0100, pack_lens(6'd0, 6'd0, 6'd0, 6'd0));
    tick();
    checkOutput("t4_grant", 4'b0100, 1, 0, 1, 0, 1);
    applyStimulus(4'b0000, pack_lens(6'd0, 6'd0, 6'd0, 6'd0));
    for (int c = 1; c < 64; c++) begin
      tick();
      checkOutput("t4_count", 4'b0100, 1, 6'(c), 1, 0, 1);
    end
    tick();
    checkOutput("t4_done", 4'b0000, 0, 63, 1, 1, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t4_hold", 4'b0000, 0, 63, 0, 0, 2);
    end

    // 5: reset in mid-burst on requester 1 (ptr is 3 here)
    applyStimulus(4'b0010, pack_lens(6'd0, 6'd10, 6'd0, 6'd0));
    tick();
    checkOutput("t5_grant", 4'b0010, 1, 0, 1, 0, 2);
    applyStimulus(4'b0000, pack_lens(6'd0, 6'd10, 6'd0, 6'd0));
    tick();
    tick();
    tick();
    checkOutput("t5_cnt3", 4'b0010, 1, 3, 1, 0, 2);
    rst = 1'b1;
    #1 checkOutput("t5_async_rst", 4'b0000, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    applyStimulus(4'b1010, pack_lens(6'd0, 6'd2, 6'd0, 6'd3));
    tick();
    checkOutput("t5_regrant", 4'b0010, 1, 0, 1, 0, 0);
    applyStimulus(4'b0000, pack_lens(6'd0, 6'd2, 6'd0, 6'd3));
    tick();
    checkOutput("t5_count1", 4'b0010, 1, 1, 1, 0, 0);
    tick();
    checkOutput("t5_done", 4'b0000, 0, 1, 1, 1, 1);
    tick();
    checkOutput("t5_idle", 4'b0000, 0, 1, 0, 0, 1);

    // 6: drop req[0] and raise req[3] during the burst (ptr is 2 here)
    applyStimulus(4'b0001, pack_lens(6'd4, 6'd0, 6'd0, 6'd0));
    tick();
    checkOutput("t6_grant", 4'b0001, 1, 0, 1, 0, 1);
    tick();
    checkOutput("t6_cnt1", 4'b0001, 1, 1, 1, 0, 1);
    applyStimulus(4'b0000, pack_lens(6'd4, 6'd0, 6'd0, 6'd0));
    tick();
    checkOutput("t6_cnt2", 4'b0001, 1, 2, 1, 0, 1);
    applyStimulus(4'b1000, pack_lens(6'd4, 6'd0, 6'd0, 6'd3));
    tick();
    checkOutput("t6_cnt3", 4'b0001, 1, 3, 1, 0, 1);
    tick();
    checkOutput("t6_done", 4'b0000, 0, 3, 1, 1, 0);
    tick();
    checkOutput("t6_idle", 4'b0000, 0, 3, 0, 0, 0);
    tick();
    checkOutput("t6_grant3", 4'b1000, 1, 0, 1, 0, 0);
    applyStimulus(4'b0000, pack_lens(6'd4, 6'd0, 6'd0, 6'd3));
    tick();
    checkOutput("t6_r3_cnt1", 4'b1000, 1, 1, 1, 0, 0);
    tick();
    checkOutput("t6_r3_cnt2", 4'b1000, 1, 2, 1, 0, 0);
    tick();
    checkOutput("t6_r3_done", 4'b0000, 0, 2, 1, 1, 3);
    tick();
    checkOutput("t6_r3_idle", 4'b0000, 0, 2, 0, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
